// File: rtl/noc_pkg.sv
// Shared types and defaults for the packet bucket.
// Channel FSM states and the default packet/address field layout.
package noc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_e;

  localparam int DEF_WIDTH_PACKET = 14;
  localparam int DEF_ADDR_LSB     = 0;
  localparam int DEF_ADDR_W       = 4;

endpackage

// File: rtl/data_bucket_chan.sv
// One receive channel: ready/hold FSM with a backward-delay counter.
// Ready comes only from state, never from in_valid.
module data_bucket_chan
  import noc_pkg::*;
#(
  parameter int BL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  output logic accept,
  output logic busy
);

  localparam logic [3:0] HOLD_INIT = (BL > 0) ? 4'(BL - 1) : 4'd0;

  chan_state_e state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic        live_q, live_d;

  assign in_ready = live_q & (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == HOLD);

  always_comb begin
    live_d  = 1'b1;
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (BL > 0)) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: rtl/data_bucket_mc.sv
// Multi-channel packet sink: per-channel accept counts, totals,
// destination-mismatch count and capture of the latest packet.
module data_bucket_mc
  import noc_pkg::*;
#(
  parameter int NODE         = 0,
  parameter int WIDTH_packet = DEF_WIDTH_PACKET,
  parameter int NUM_CH       = 4,
  parameter int BL           = 1,
  parameter int ADDR_LSB     = DEF_ADDR_LSB,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*WIDTH_packet-1:0] in_data,
  input  logic                       clear,
  output logic [NUM_CH*CNT_W-1:0]    rx_count,
  output logic [CNT_W-1:0]           total_count,
  output logic [CNT_W-1:0]           err_count,
  output logic [WIDTH_packet-1:0]    last_data,
  output logic [2:0]                 last_ch,
  output logic                       busy
);

  localparam logic [ADDR_W-1:0] NODE_A = ADDR_W'(NODE);

  logic [NUM_CH-1:0]       accept;
  logic [NUM_CH-1:0]       busy_vec;
  logic [WIDTH_packet-1:0] pkt [NUM_CH];

  logic [CNT_W-1:0]        rx_q [NUM_CH];
  logic [CNT_W-1:0]        rx_d [NUM_CH];
  logic [CNT_W-1:0]        total_q, total_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic [WIDTH_packet-1:0] last_data_q, last_data_d;
  logic [2:0]              last_ch_q, last_ch_d;
  logic [3:0]              acc_cnt, err_inc;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [3:0]       b
  );
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(a) + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    data_bucket_chan #(
      .BL(BL)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[k]),
      .in_ready (in_ready[k]),
      .accept   (accept[k]),
      .busy     (busy_vec[k])
    );
    assign pkt[k] = in_data[k*WIDTH_packet +: WIDTH_packet];
    assign rx_count[k*CNT_W +: CNT_W] = rx_q[k];
  end

  always_comb begin
    acc_cnt     = 4'd0;
    err_inc     = 4'd0;
    last_data_d = last_data_q;
    last_ch_d   = last_ch_q;
    for (int k = 0; k < NUM_CH; k++) begin
      acc_cnt = acc_cnt + 4'(accept[k]);
      if (accept[k] && (pkt[k][ADDR_LSB +: ADDR_W] != NODE_A)) begin
        err_inc = err_inc + 4'd1;
      end
      rx_d[k] = accept[k] ? sat_add(rx_q[k], 4'd1) : rx_q[k];
    end
    // walk downward so the lowest accepting channel wins the capture
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (accept[k]) begin
        last_data_d = pkt[k];
        last_ch_d   = 3'(k);
      end
    end
    total_d = sat_add(total_q, acc_cnt);
    err_d   = sat_add(err_q, err_inc);
    if (clear) begin
      for (int k = 0; k < NUM_CH; k++) rx_d[k] = '0;
      total_d     = '0;
      err_d       = '0;
      last_data_d = '0;
      last_ch_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) rx_q[k] <= '0;
      total_q     <= '0;
      err_q       <= '0;
      last_data_q <= '0;
      last_ch_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) rx_q[k] <= rx_d[k];
      total_q     <= total_d;
      err_q       <= err_d;
      last_data_q <= last_data_d;
      last_ch_q   <= last_ch_d;
    end
  end

  assign total_count = total_q;
  assign err_count   = err_q;
  assign last_data   = last_data_q;
  assign last_ch     = last_ch_q;
  assign busy        = |busy_vec;

endmodule

// File: doc/data_bucket_mc.md
DATA_BUCKET_MC -- requirements
Module: data_bucket_mc

Interface
REQ-001 Parameter NODE, default 0: this node's address, compared against each packet's destination field.
REQ-002 Parameter WIDTH_packet, default 14: packet width in bits.
REQ-003 Parameter NUM_CH, default 4: number of receive channels, range 1..8.
REQ-004 Parameter BL, default 1: backward delay, range 0..15; cycles ready stays low after each accept.
REQ-005 Parameter ADDR_LSB, default 0, and ADDR_W, default 4: position and width of the destination field.
REQ-006 Parameter CNT_W, default 16: width of every counter.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 in_valid  in  NUM_CH  per-channel packet valid.
REQ-011 in_ready  out  NUM_CH  per-channel ready.
REQ-012 in_data  in  NUM_CH*WIDTH_packet  per-channel packet; channel k occupies bits [k*WIDTH_packet +: WIDTH_packet].
REQ-013 clear  in  1  synchronous clear of all counters and capture registers.
REQ-014 rx_count  out  NUM_CH*CNT_W  per-channel accepted-packet count.
REQ-015 total_count  out  CNT_W  accepts summed over all channels.
REQ-016 err_count  out  CNT_W  accepted packets whose destination field differs from NODE.
REQ-017 last_data  out  WIDTH_packet  most recently accepted packet.
REQ-018 last_ch  out  3  channel index of last_data.
REQ-019 busy  out  1  OR of all channels in HOLD.

Function
REQ-020 Handshake: an accept on channel k occurs in a cycle where in_valid[k] and in_ready[k] are both 1.
REQ-021 Handshake rule: in_ready does not depend combinationally on in_valid.
REQ-022 Per-channel FSM, state IDLE: in_ready=1; an accept with BL>0 moves the channel to HOLD and loads the hold counter with BL-1.
REQ-023 Per-channel FSM, state HOLD: in_ready=0; hold counter decrements each cycle; at counter 0 the channel returns to IDLE on the next edge.
REQ-024 BL=0: the channel stays in IDLE, with in_ready constantly 1 outside reset.
REQ-025 Accept spacing: with in_valid held high, accepts on one channel occur exactly every BL+1 cycles.
REQ-026 rx_count[k] increments by 1 per accept on channel k.
REQ-027 total_count increments by the number of channels accepting that cycle, i.e. the popcount, 0..NUM_CH.
REQ-028 err_count increments by the number of accepting channels whose data[ADDR_LSB +: ADDR_W] != NODE[ADDR_W-1:0].
REQ-029 All counters saturate at all-ones and never wrap.
REQ-030 Simultaneous accepts: last_data/last_ch take the lowest-index accepting channel; all counts still include every accepting channel.
REQ-031 Capture latency: counters and last_data update on the edge that completes the accept and are visible the following cycle.
REQ-032 clear=1: zeroes all counters, last_data and last_ch on the next edge, overriding any accept in that cycle.
REQ-033 clear does not change FSM state, so an in-progress HOLD completes normally.
REQ-034 Input validity: in_data of a channel is ignored unless that channel accepts.

Reset
REQ-035 rst_n low asynchronously forces every channel to IDLE, all hold counters to 0, all counters to 0, last_data and last_ch to 0, and busy to 0.
REQ-036 While rst_n is low, in_ready = 0.
REQ-037 After release of rst_n, in_ready = all ones from the first rising edge.
REQ-038 Reset asserted mid-HOLD aborts the hold without an extra accept.

Structure
REQ-039 Shared package noc_pkg holds the channel FSM state enum (IDLE, HOLD) and the default packet-width and address-field constants.
REQ-040 The per-channel FSM and hold counter are one sub-module, data_bucket_chan, instantiated NUM_CH times by a generate loop; counters, capture and priority select are in the top.

Verification
REQ-041 Test 1: NODE=0, BL=1; channel 0 sends 5 back-to-back packets with dest 0 -> accepts 2 cycles apart, rx_count[0]=5, total_count=5, err_count=0.
REQ-042 Test 2: BL=0; channel 2 holds valid for 10 cycles -> in_ready[2] stays 1, rx_count[2]=10.
REQ-043 Test 3: channels 1 and 3 accept in the same cycle with data 14'h0011 and 14'h0023 -> total_count +2, last_ch=1, last_data=14'h0011, err_count +2.
REQ-044 Test 4: CNT_W=4; 20 accepts on one channel -> rx_count=15, total_count=15.
REQ-045 Test 5: clear asserted in the same cycle as an accept -> all counts 0 the next cycle; the channel is still in HOLD for BL cycles.
REQ-046 Test 6: rst_n pulled low mid-HOLD with BL=5 -> in_ready=0 and all counts 0 immediately; in_ready=1 after release.
